// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin credit, vend and nickel-change controller.
// Optional idle auto-refund is enabled by defining VEND_AUTO_REFUND_EN.
module vend_credit_fsm #(
  parameter int PRICE           = 75,
  parameter int MAX_CREDIT      = 195,
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] debounced,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       change_nickel,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  localparam int DW =
    (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(DISPENSE_CYCLES - 1);
  localparam logic [8:0] MAXC = 9'(MAX_CREDIT);
  localparam logic [7:0] PRICE8 = 8'(PRICE);

  if ((PRICE % 5) != 0 || PRICE > MAX_CREDIT ||
      (MAX_CREDIT % 5) != 0 || MAX_CREDIT > 255 ||
      DISPENSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("vend_credit_fsm: illegal parameter set");
  end

  state_t        state;
  logic [3:0]    prev;
  logic [3:0]    ev;
  logic [DW-1:0] dcnt;
  logic          phase;
  logic [7:0]    val;
  logic [8:0]    sum;
  logic          coin_any;
  logic          coin_one;
  logic          fits;
  logic          vend_ev;

`ifdef VEND_AUTO_REFUND_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt;
`endif

  // rising-edge events, coin value and overflow check
  always_comb begin
    ev       = debounced & ~prev;
    coin_any = |ev[2:0];
    coin_one = coin_any &&
               ((ev[2:0] & (ev[2:0] - 3'd1)) == 3'd0);
    vend_ev  = ev[3] & ~coin_any;
    val      = 8'd0;
    case (ev[2:0])
      3'b001:  val = 8'd5;
      3'b010:  val = 8'd10;
      3'b100:  val = 8'd25;
      default: val = 8'd0;
    endcase
    sum  = {1'b0, credit} + {1'b0, val};
    fits = (sum <= MAXC);
  end

  // edge history, credit bookkeeping and vend/change sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev          <= 4'b1111;
      state         <= S_IDLE;
      credit        <= 8'd0;
      dispense      <= 1'b0;
      change_nickel <= 1'b0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
      dcnt          <= '0;
      phase         <= 1'b0;
`ifdef VEND_AUTO_REFUND_EN
      idle_cnt      <= '0;
`endif
    end else begin
      prev          <= debounced;
      coin_reject   <= 1'b0;
      change_nickel <= 1'b0;
`ifdef VEND_AUTO_REFUND_EN
      idle_cnt      <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (coin_any) begin
            if (coin_one && fits) begin
              credit <= sum[7:0];
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (vend_ev) begin
            if (credit >= PRICE8) begin
              credit   <= credit - PRICE8;
              state    <= S_DISPENSE;
              dispense <= 1'b1;
              busy     <= 1'b1;
              dcnt     <= DLOAD;
            end else if (credit != 8'd0) begin
              state <= S_CHANGE;
              busy  <= 1'b1;
              phase <= 1'b0;
            end
          end
`ifdef VEND_AUTO_REFUND_EN
          else if (credit != 8'd0) begin
            if (idle_cnt == TLAST) begin
              state <= S_CHANGE;
              busy  <= 1'b1;
              phase <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        S_DISPENSE: begin
          if (coin_any) coin_reject <= 1'b1;
          if (dcnt == '0) begin
            dispense <= 1'b0;
            if (credit != 8'd0) begin
              state <= S_CHANGE;
              phase <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        S_CHANGE: begin
          if (coin_any) coin_reject <= 1'b1;
          if (!phase) begin
            change_nickel <= 1'b1;
            credit        <= credit - 8'd5;
            phase         <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (credit == 8'd0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb_vend_credit_fsm: directed vector bench for vend_credit_fsm.
// Auto-refund sequence runs only when VEND_AUTO_REFUND_EN is defined.
module tb_vend_credit_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] debounced;
  logic [7:0] credit;
  logic       dispense;
  logic       change_nickel;
  logic       coin_reject;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] din;
    logic [7:0] credit;
    logic       disp;
    logic       cn;
    logic       rej;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  vend_credit_fsm #(
    .PRICE(75),
    .MAX_CREDIT(195),
    .DISPENSE_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .debounced(debounced),
    .credit(credit),
    .dispense(dispense),
    .change_nickel(change_nickel),
    .coin_reject(coin_reject),
    .busy(busy)
  );

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] d, input int c,
                     input logic di, input logic cn,
                     input logic rj, input logic b);
    vec_t v;
    v.din    = d;
    v.credit = 8'(c);
    v.disp   = di;
    v.cn     = cn;
    v.rej    = rj;
    v.busy   = b;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int c,
                         input logic di, input logic cn,
                         input logic rj, input logic b);
    chk({tag, ".credit"}, credit, 8'(c));
    chk({tag, ".dispense"}, {7'd0, dispense}, {7'd0, di});
    chk({tag, ".change"}, {7'd0, change_nickel}, {7'd0, cn});
    chk({tag, ".reject"}, {7'd0, coin_reject}, {7'd0, rj});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  // called on a falling edge; one row per clock cycle
  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      debounced = tbl[i].din;
      @(negedge clk);
      chk_all($sformatf("%s[%0d]", tag, i), int'(tbl[i].credit),
              tbl[i].disp, tbl[i].cn, tbl[i].rej, tbl[i].busy);
    end
    tbl.delete();
  endtask

  initial begin
    reset     = 1'b1;
    debounced = 4'b0001;
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("held_nickel[%0d].credit", i), credit, 8'd0);
      chk($sformatf("held_nickel[%0d].reject", i),
          {7'd0, coin_reject}, 8'd0);
    end

    // three quarters then an exact vend
    add(4'b0000, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      add(4'b0100, 25 * k, 0, 0, 0, 0);
      add(4'b0000, 25 * k, 0, 0, 0, 0);
    end
    add(4'b1000, 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(4'b0000, 0, 1, 0, 0, 1);
    add(4'b0000, 0, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 0);
    run_tbl("exact");

    // 100 cents, vend, then 25 cents of change
    for (int k = 1; k <= 4; k++) begin
      add(4'b0100, 25 * k, 0, 0, 0, 0);
      add(4'b0000, 25 * k, 0, 0, 0, 0);
    end
    add(4'b1000, 25, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(4'b0000, 25, 1, 0, 0, 1);
    add(4'b0000, 25, 0, 0, 0, 1);
    for (int c = 20; c >= 0; c -= 5) begin
      add(4'b0000, c, 0, 1, 0, 1);
      add(4'b0000, c, 0, 0, 0, (c != 0));
    end
    add(4'b0000, 0, 0, 0, 0, 0);
    run_tbl("change");

    // double coin, vend at zero, overflow at 175
    add(4'b0011, 0, 0, 0, 1, 0);
    add(4'b0000, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      add(4'b0100, 25 * k, 0, 0, 0, 0);
      add(4'b0000, 25 * k, 0, 0, 0, 0);
    end
    add(4'b0100, 175, 0, 0, 1, 0);
    add(4'b0000, 175, 0, 0, 0, 0);
    run_tbl("reject");

    // reset in the middle of DISPENSE
    debounced = 4'b1000;
    @(negedge clk);
    chk_all("midreset_vend", 100, 1'b1, 1'b0, 1'b0, 1'b1);
    debounced = 4'b0000;
    @(negedge clk);
    chk_all("midreset_disp", 100, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all("midreset_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_all($sformatf("post_reset[%0d]", i), 0,
              1'b0, 1'b0, 1'b0, 1'b0);
    end

    // coin+vend together, short refund, coin during CHANGE
    add(4'b1010, 10, 0, 0, 0, 0);
    add(4'b0000, 10, 0, 0, 0, 0);
    add(4'b1000, 10, 0, 0, 0, 1);
    add(4'b0100, 5, 0, 1, 1, 1);
    add(4'b0000, 5, 0, 0, 0, 1);
    add(4'b0000, 0, 0, 1, 0, 1);
    add(4'b0000, 0, 0, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 0);
    run_tbl("refund");

`ifdef VEND_AUTO_REFUND_EN
    begin
      int  k;
      bit  got;
      debounced = 4'b0001;
      @(negedge clk);
      chk("auto.credit", credit, 8'd5);
      debounced = 4'b0000;
      k   = 0;
      got = 1'b0;
      while (k < 40 && !got) begin
        @(negedge clk);
        k++;
        if (change_nickel) got = 1'b1;
      end
      chk("auto.delay", 8'(k), 8'd21);
      repeat (3) @(negedge clk);
      chk("auto.credit_end", credit, 8'd0);
      chk("auto.busy_end", {7'd0, busy}, 8'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Credit and vend controller for the vending machine, directly downstream of the 4-bit button debouncer. Takes the four debounced button levels, turns rising edges into coin-insert and vend-request events, and keeps a running credit. Drives a dispense strobe and returns change one nickel pulse at a time. Everything runs on the single system clock.

## Interface
- PRICE, 75: item price in cents; must be a multiple of 5 and no greater than MAX_CREDIT.
- MAX_CREDIT, 195: highest credit accepted, in cents; multiple of 5, at most 255.
- DISPENSE_CYCLES, 4: number of cycles `dispense` stays high per vend; must be at least 1.
- TIMEOUT_CYCLES, 1000000: idle cycles before auto-refund; used only with VEND_AUTO_REFUND_EN.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- debounced  input  4  debounced button levels: bit0 nickel (5), bit1 dime (10), bit2 quarter (25), bit3 vend/refund request.
- credit  output  8  current credit in cents, registered.
- dispense  output  1  high for DISPENSE_CYCLES consecutive cycles per vend.
- change_nickel  output  1  one-cycle pulse per 5 cents returned.
- coin_reject  output  1  one-cycle pulse when a coin event is refused.
- busy  output  1  high in DISPENSE and CHANGE.

## Operation
- Edge detection:
  - A registered `prev` copy of `debounced` is kept.
  - event[i] = debounced[i] & ~prev[i].
  - `prev` resets to 4'b1111, so a button held through reset produces no event after reset is released.
  - `prev` updates every cycle in every state.
- FSM states are IDLE, DISPENSE and CHANGE. Reset state is IDLE.
- IDLE, coin handling:
  - If exactly one coin event (bits 0..2) is present and credit+value ≤ MAX_CREDIT, credit += value.
  - If the sum would exceed MAX_CREDIT, credit is unchanged and coin_reject pulses.
  - If two or more coin events arrive in the same cycle, all are refused, credit is unchanged, and coin_reject pulses once.
- IDLE, vend handling:
  - An event on bit3 in a cycle with no coin event triggers vend handling.
  - If credit ≥ PRICE: credit -= PRICE, then go to DISPENSE.
  - Else if credit > 0: go to CHANGE (refund).
  - Else: ignored.
  - If bit3 and a coin event occur in the same cycle, the coin is processed and the vend event is discarded.
- DISPENSE:
  - `dispense` is high for DISPENSE_CYCLES cycles, timed by a down-counter.
  - Afterwards, go to CHANGE if credit > 0, else to IDLE.
- CHANGE:
  - Alternates a pulse cycle and a gap cycle.
  - Each pulse cycle asserts change_nickel and sets credit -= 5.
  - When credit reaches 0, return to IDLE after the gap cycle.
- In DISPENSE and CHANGE:
  - Any coin event pulses coin_reject; credit is unchanged.
  - bit3 events are ignored.
- Arithmetic:
  - credit is 8-bit unsigned and always a multiple of 5.
  - The sum is computed 9 bits wide before the compare, so no wrap-around occurs.

## Timing
- Reset values: credit=0, dispense=0, change_nickel=0, coin_reject=0, busy=0, state IDLE, counters 0.
- Coin latency: debounced[i] rises and is first sampled at edge N → credit updated at edge N, so the new value is visible for the cycle after edge N.
- Vend:
  - A vend event at edge N sets dispense and busy from edge N.
  - dispense falls at edge N+DISPENSE_CYCLES.
- Refund of C cents takes 2·C/5 cycles:
  - change_nickel is high in every other cycle, starting the cycle after CHANGE is entered.
  - busy falls in the same cycle the FSM returns to IDLE.
- Reset asserted mid-DISPENSE or mid-CHANGE:
  - All outputs clear immediately (asynchronous).
  - Any remaining credit is lost, and no change pulses are emitted after reset.

## Configuration
- VEND_AUTO_REFUND_EN defined:
  - An idle counter runs in IDLE while credit > 0.
  - It clears on any accepted or rejected event, and on leaving IDLE.
  - On reaching TIMEOUT_CYCLES it forces a transition to CHANGE, refunding all credit.
- VEND_AUTO_REFUND_EN undefined:
  - Neither the counter nor the timeout logic exists.
  - Credit is held indefinitely in IDLE.

## Test plan
- Reset with debounced=4'b0001 held, release reset, hold 10 cycles → credit stays 0 and no coin_reject pulse.
- Quarter, quarter, quarter, then vend → credit 25/50/75, then credit 0, dispense high exactly 4 cycles, no change_nickel.
- Quarter ×4 (100), then vend → credit 25, dispense 4 cycles, then 5 change_nickel pulses spaced 2 cycles apart, credit 0, busy low.
- Nickel and dime rising in the same cycle → credit unchanged and one coin_reject pulse. Quarters up to 175, then a quarter → credit 175 and coin_reject pulse.
- Dime, then vend with credit 10 → 2 change_nickel pulses and no dispense. A quarter inserted during CHANGE → coin_reject pulse and credit unaffected.
- Vend with credit 100, assert reset during DISPENSE → all outputs 0 immediately and credit 0 after reset releases. With VEND_AUTO_REFUND_EN and TIMEOUT_CYCLES=20, a nickel then idle → change_nickel pulse after 20 cycles.
